// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin arbiter sharing one two-stage FP32 multiplier among N requesters

module fmul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        error,
    output logic        overflow
);
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [47:0] prod;
    logic        norm;
    logic [22:0] frac;
    logic [9:0]  exp_raw;
    logic [9:0]  exp_out;
    logic        unused_bits;

    always_comb begin
        sign    = a[31] ^ b[31];
        ea      = a[30:23];
        eb      = b[30:23];
        a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
        // Subnormal operands are flushed to zero.
        a_zero  = (ea == 8'h00);
        b_zero  = (eb == 8'h00);
        ma      = {1'b1, a[22:0]};
        mb      = {1'b1, b[22:0]};
        prod    = {24'd0, ma} * {24'd0, mb};
        norm    = prod[47];
        frac    = norm ? prod[46:24] : prod[45:23];
        exp_raw = {2'b00, ea} + {2'b00, eb} + {9'd0, norm};
        exp_out = exp_raw - 10'd127;
        error    = 1'b0;
        overflow = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            result = {sign, 8'hFF, 23'h400000};
            error  = 1'b1;
        end else if (a_inf || b_inf) begin
            result = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            result = {sign, 31'd0};
        end else if (exp_raw >= 10'd382) begin
            result   = {sign, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else if (exp_raw <= 10'd127) begin
            result = {sign, 31'd0};
        end else begin
            result = {sign, exp_out[7:0], frac};
        end
    end

    assign unused_bits = ^{prod[22:0], exp_out[9:8]};
endmodule

module fmul_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [31:0]       resp_result,
    output logic              resp_error,
    output logic              resp_overflow
);
    localparam logic [IDW:0]   N_W  = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST = IDW'(N-1);

    logic           s1_valid_q, s1_valid_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic [31:0]    s1_a_q, s1_a_d;
    logic [31:0]    s1_b_q, s1_b_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [31:0]    resp_result_q, resp_result_d;
    logic           resp_error_q, resp_error_d;
    logic           resp_overflow_q, resp_overflow_d;

    logic [31:0]    a_arr [N];
    logic [31:0]    b_arr [N];
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           s2_adv, s1_adv, accept;
    logic [31:0]    f_result;
    logic           f_error, f_overflow;

    fmul u_fmul (
        .a        (s1_a_q),
        .b        (s1_b_q),
        .result   (f_result),
        .error    (f_error),
        .overflow (f_overflow)
    );

    // Search upward from rr_ptr, wrapping modulo N; first valid requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            a_arr[k] = req_a[32*k +: 32];
            b_arr[k] = req_b[32*k +: 32];
        end
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= N_W) sum = sum - N_W;
            idx = sum[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_comb begin
        s2_adv    = ~resp_valid_q | resp_ready;
        s1_adv    = ~s1_valid_q | s2_adv;
        req_ready = rst_n ? (grant & {N{s1_adv}}) : '0;
        accept    = |req_ready;

        s1_valid_d      = s1_valid_q;
        s1_id_d         = s1_id_q;
        s1_a_d          = s1_a_q;
        s1_b_d          = s1_b_q;
        rr_ptr_d        = rr_ptr_q;
        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_result_d   = resp_result_q;
        resp_error_d    = resp_error_q;
        resp_overflow_d = resp_overflow_q;

        if (s2_adv) begin
            resp_valid_d    = s1_valid_q;
            resp_id_d       = s1_id_q;
            resp_result_d   = f_result;
            resp_error_d    = f_error;
            resp_overflow_d = f_overflow;
        end
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_id_d = grant_id;
                s1_a_d  = a_arr[grant_id];
                s1_b_d  = b_arr[grant_id];
            end
        end
        if (accept) begin
            rr_ptr_d = (grant_id == LAST) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_id_q         <= '0;
            s1_a_q          <= '0;
            s1_b_q          <= '0;
            rr_ptr_q        <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_result_q   <= '0;
            resp_error_q    <= 1'b0;
            resp_overflow_q <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_id_q         <= s1_id_d;
            s1_a_q          <= s1_a_d;
            s1_b_q          <= s1_b_d;
            rr_ptr_q        <= rr_ptr_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_result_q   <= resp_result_d;
            resp_error_q    <= resp_error_d;
            resp_overflow_q <= resp_overflow_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_result   = resp_result_q;
    assign resp_error    = resp_error_q;
    assign resp_overflow = resp_overflow_q;
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb/tb_fmul_arbiter.sv - directed self-checking bench for fmul_arbiter

module tb_fmul_arbiter;
    localparam int N = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [IDW-1:0]  resp_id;
    logic [31:0]     resp_result;
    logic            resp_error;
    logic            resp_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] vals [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] dbl  [3] = '{32'h40000000, 32'h40800000, 32'h40C00000};

    int bp_rdy [7] = '{0, 0, 0, 1, 1, 1, 1};
    int bp_val [7] = '{1, 1, 1, 1, 0, 0, 0};
    int bp_op  [7] = '{0, 1, 2, 2, 0, 0, 0};
    int bp_err [7] = '{1, 1, 0, 1, 0, 0, 0};
    int bp_erv [7] = '{0, 0, 1, 1, 1, 1, 0};
    int bp_res [7] = '{0, 0, 0, 0, 1, 2, 0};

    fmul_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_error    (resp_error),
        .resp_overflow (resp_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input string tag, input int id, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res,
                             input logic exp_err, input logic exp_ovf);
        resp_ready = 1'b1;
        req_valid  = '0;
        req_valid[id] = 1'b1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        #2;
        check_eq({tag, "_ready"}, req_ready, 64'(1 << id));
        step();
        req_valid = '0;
        step();
        #2;
        check_eq({tag, "_valid"}, resp_valid, 1);
        check_eq({tag, "_id"}, resp_id, id);
        check_eq({tag, "_result"}, resp_result, exp_res);
        check_eq({tag, "_error"}, resp_error, exp_err);
        check_eq({tag, "_overflow"}, resp_overflow, exp_ovf);
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '1;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;
        step();
        step();
        #2;
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_id", resp_id, 0);
        check_eq("rst_resp_result", resp_result, 0);
        check_eq("rst_resp_error", resp_error, 0);
        check_eq("rst_resp_overflow", resp_overflow, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rr_ptr", dut.rr_ptr_q, 0);
        step();
        rst_n = 1'b1;

        // Fairness: all four requesters held valid for eight cycles.
        for (int r = 0; r < N; r++) begin
            req_a[32*r +: 32] = 32'h3F800000;
            req_b[32*r +: 32] = vals[r];
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i < 8) ? 4'hF : 4'h0;
            #2;
            if (i < 8) check_eq($sformatf("fair_grant_%0d", i), req_ready, 64'(1 << (i % 4)));
            if (i >= 2) begin
                check_eq($sformatf("fair_valid_%0d", i), resp_valid, 1);
                check_eq($sformatf("fair_id_%0d", i), resp_id, (i - 2) % 4);
                check_eq($sformatf("fair_result_%0d", i), resp_result, vals[(i - 2) % 4]);
            end
            step();
        end
        #2;
        check_eq("fair_drained", resp_valid, 0);

        issue_one("single", 1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
        issue_one("inf_x_zero", 2, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0);
        issue_one("inf_x_ninf", 3, 32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0);
        issue_one("one_x_zero", 0, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        issue_one("overflow", 1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1);
        issue_one("nan_in", 2, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0);
        issue_one("underflow", 3, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0);
        issue_one("neg", 0, 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0, 1'b0);
        issue_one("trunc", 0, 32'h3FC00000, 32'h3F800001, 32'h3FC00001, 1'b0, 1'b0);

        // Backpressure: requester 0 streams while the consumer stalls for three cycles.
        req_a[31:0] = 32'h40000000;
        for (int c = 0; c < 7; c++) begin
            resp_ready  = (bp_rdy[c] != 0);
            req_valid   = (bp_val[c] != 0) ? 4'b0001 : 4'b0000;
            req_b[31:0] = vals[bp_op[c]];
            #2;
            check_eq($sformatf("bp_ready_%0d", c), req_ready, 64'(bp_err[c]));
            check_eq($sformatf("bp_valid_%0d", c), resp_valid, 64'(bp_erv[c]));
            if (bp_erv[c] != 0) begin
                check_eq($sformatf("bp_result_%0d", c), resp_result, dbl[bp_res[c]]);
                check_eq($sformatf("bp_id_%0d", c), resp_id, 0);
            end
            step();
        end

        // Reset mid-flight with both stages occupied.
        resp_ready = 1'b0;
        req_valid  = 4'b0100;
        req_a[64 +: 32] = 32'h40000000;
        req_b[64 +: 32] = 32'h3F800000;
        step();
        req_b[64 +: 32] = 32'h40000000;
        step();
        #2;
        check_eq("mid_pre_valid", resp_valid, 1);
        check_eq("mid_pre_rr_ptr", dut.rr_ptr_q, 3);
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        #2;
        check_eq("mid_rst_valid", resp_valid, 0);
        check_eq("mid_rst_rr_ptr", dut.rr_ptr_q, 0);
        check_eq("mid_rst_id", resp_id, 0);
        check_eq("mid_rst_result", resp_result, 0);
        check_eq("mid_rst_error", resp_error, 0);
        check_eq("mid_rst_overflow", resp_overflow, 0);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #2;
            check_eq($sformatf("mid_no_stale_%0d", i), resp_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fmul_arbiter.md
# fmul_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one `FMUL` instance among `N` requesters over valid/ready handshakes. Each requester presents packed IEEE-754 single-precision operands; the block grants one per cycle, registers operands into the multiplier, and registers the result with the winner's ID and the exception flags. It sits between the operand-producing units and the FP multiplier, and replaces per-unit `FMUL` copies.

## Interface
- `N`, 4: number of requesters (2..8).
- `IDW`, `$clog2(N)`: requester ID width.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  N: bit i means requester i has an operand pair.
- `req_ready`  out  N: bit i means requester i's pair is accepted this cycle; one-hot or zero.
- `req_a`  in  32*N: operand A of requester i at bits [32i+31:32i], as {sign, exp[7:0], frac[22:0]}.
- `req_b`  in  32*N: operand B, same packing.
- `resp_valid`  out  1: result register holds a result.
- `resp_ready`  in  1: consumer accepts the result.
- `resp_id`  out  IDW: requester that issued the result.
- `resp_result`  out  32: {sign, exp[7:0], frac[23:1]} from `FMUL`.
- `resp_error`  out  1: `FMUL` error (NaN operand, or inf×0).
- `resp_overflow`  out  1: `FMUL` overflow.

## Operation
- Stage S1 holds `s1_valid`, `s1_id`, `s1_a`, `s1_b`. The `FMUL` instance is driven combinationally from the S1 registers.
- Stage S2 holds `resp_valid`, `resp_id`, `resp_result`, `resp_error`, `resp_overflow`. S2 captures the `FMUL` outputs.
- Stall rule:
  - `s2_adv = ~resp_valid | resp_ready`.
  - `s1_adv = ~s1_valid | s2_adv`.
  - S2 loads `{s1_valid, s1_id, fmul outputs}` when `s2_adv`.
  - S1 loads the granted pair when `s1_adv`. If no request is granted, S1 loads `s1_valid=0`.
- Arbitration:
  - `rr_ptr` (IDW bits) points to the highest-priority requester.
  - The grant goes to the first i with `req_valid[i]=1`, searching from `rr_ptr` upward and wrapping modulo N.
  - `req_ready[i] = grant[i] & s1_adv`.
  - On acceptance, `rr_ptr` becomes (granted ID + 1) mod N. Otherwise `rr_ptr` holds.
- Requesters hold `req_valid` and their operands stable until accepted. `req_ready` may depend combinationally on `req_valid` and `resp_ready`. `req_valid` does not depend on `req_ready`.
- Result packing drops `frac[0]` (truncation, no rounding):
  - NaN returns exp FF with `frac[23:1]`=0x400000.
  - Zero and underflow return exp 00 with frac 0.
  - Overflow returns exp FF with frac 0 and `resp_overflow=1`.
- Sign is always A_sign XOR B_sign, including for special results.
- The block does not reorder results: responses leave in acceptance order.

## Timing
- Reset (`rst_n`=0 at a clock edge) sets:
  - `s1_valid`=0, `resp_valid`=0, `rr_ptr`=0.
  - `resp_id`=0, `resp_result`=0, `resp_error`=0, `resp_overflow`=0.
  - `req_ready` is 0 while `rst_n`=0.
- Reset mid-operation flushes S1 and S2 without issuing responses. In-flight requests are lost, and requesters re-present them after reset.
- Latency is 2 cycles. A pair accepted at edge k appears with `resp_valid=1` after edge k+1 and is consumed at the first edge ≥ k+1 where `resp_ready=1`.
- Throughput is 1 result/cycle while `resp_ready=1`.
- Full pipeline: `resp_valid=1`, `resp_ready=0` and `s1_valid=1` force `req_ready`=0. S1 and S2 hold their contents bit-exact.
- A consumer pop and a new grant in the same cycle shift both stages (no bubble).
- With a single active requester, that requester is granted every cycle, regardless of `rr_ptr`.
- With no requester active, `rr_ptr` holds and a bubble enters S1.

## Test plan
- Single request: req 1 presents a=0x40000000, b=0x40400000 with `resp_ready`=1. Required: `req_ready[1]`=1 in the same cycle, then 2 edges later `resp_valid`=1, `resp_id`=1, `resp_result`=0x40C00000, `resp_error`=0, `resp_overflow`=0.
- Fairness: all 4 requesters hold `req_valid`=1 for 8 cycles with `resp_ready`=1. Required: grant order 0,1,2,3,0,1,2,3 and `resp_id` in the same order, one per cycle.
- Backpressure: stream from req 0 with `resp_ready`=0 for 3 cycles. Required: after 2 accepts `req_ready`=0, S2 holds the first result unchanged, and after `resp_ready` returns high, results drain in order with none lost or duplicated.
- Exceptions:
  - a=0x7F800000, b=0x00000000 gives `resp_result`=0x7FC00000, `resp_error`=1.
  - a=0x7F800000, b=0xFF800000 gives 0xFF800000, `resp_error`=0.
  - a=0x3F800000, b=0x00000000 gives 0x00000000.
- Overflow: a=b=0x7F000000. Required: `resp_result`=0x7F800000, `resp_overflow`=1, `resp_error`=0.
- Reset mid-flight: two requests accepted, then `rst_n`=0 for one edge. Required: `resp_valid`=0, `rr_ptr`=0 and all `resp_*` outputs 0 after that edge, and no stale response after `rst_n` returns high.
